// File: rtl/cherry_issue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cherry_issue_pkg : lane widths, active-bit positions, FSM states    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package cherry_issue_pkg;

    localparam int DMA_INSTR_W   = 22;
    localparam int ARITH_INSTR_W = 1;
    localparam int CACHE_INSTR_W = 17;

    // Each lane's MSB doubles as its "instruction present" flag.
    localparam int DMA_ACT_BIT   = DMA_INSTR_W - 1;
    localparam int ARITH_ACT_BIT = ARITH_INSTR_W - 1;
    localparam int CACHE_ACT_BIT = CACHE_INSTR_W - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        ISSUE   = 2'd3
    } issue_state_e;

endpackage : cherry_issue_pkg
`default_nettype wire

// File: rtl/instr_issue_lane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | issue_lane : one issue lane - instr register, pending bit, retire   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module issue_lane #(
    parameter int W       = 8,
    parameter int ACT_BIT = W - 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         capture_i,
    input  logic         issue_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] instr_o,
    output logic         pending_d_o
);

    logic [W-1:0] instr_q;
    logic [W-1:0] instr_d;
    logic         pending_q;
    logic         pending_d;

    assign valid_o     = issue_i & pending_q;
    assign instr_o     = instr_q;
    assign pending_d_o = pending_d;

    always_comb begin
        instr_d   = instr_q;
        pending_d = pending_q;
        if (capture_i) begin
            instr_d   = data_i;
            pending_d = data_i[ACT_BIT];
        end else if (valid_o && ready_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pending_q <= pending_d;
        end
    end

endmodule : issue_lane
`default_nettype wire

// File: rtl/instr_issue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_issue : reads one bundle at a time and issues it on 3 lanes   |
// | Option: ISSUE_PERF_CNT_EN adds stall_cnt / bundle_cnt outputs.      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module instr_issue
    import cherry_issue_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    output logic                     q_re,
    input  logic [DMA_INSTR_W-1:0]   q_dma,
    input  logic [ARITH_INSTR_W-1:0] q_arith,
    input  logic [CACHE_INSTR_W-1:0] q_cache,
    input  logic                     q_empty,
    output logic                     dma_valid,
    output logic [DMA_INSTR_W-1:0]   dma_instr,
    input  logic                     dma_ready,
    output logic                     arith_valid,
    output logic [ARITH_INSTR_W-1:0] arith_op,
    input  logic                     arith_ready,
    output logic                     cache_valid,
    output logic [CACHE_INSTR_W-1:0] cache_instr,
    input  logic                     cache_ready,
    output logic                     busy
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [15:0]              stall_cnt,
    output logic [15:0]              bundle_cnt
`endif
);

    issue_state_e state_q;
    issue_state_e state_d;
    logic         q_re_q;
    logic         busy_q;
    logic         issue_q;
    logic         w_capture;
    logic         w_can_read;
    logic         w_any_pend_d;
    logic         dma_pend_d;
    logic         arith_pend_d;
    logic         cache_pend_d;

    assign w_capture    = (state_q == CAPTURE);
    assign w_can_read   = run & ~q_empty;
    assign w_any_pend_d = dma_pend_d | arith_pend_d | cache_pend_d;

    assign q_re = q_re_q;
    assign busy = busy_q;

    issue_lane #(.W(DMA_INSTR_W), .ACT_BIT(DMA_ACT_BIT)) u_dma_lane (
        .clk(clk), .reset(reset), .capture_i(w_capture), .issue_i(issue_q),
        .data_i(q_dma), .ready_i(dma_ready), .valid_o(dma_valid),
        .instr_o(dma_instr), .pending_d_o(dma_pend_d)
    );

    issue_lane #(.W(ARITH_INSTR_W), .ACT_BIT(ARITH_ACT_BIT)) u_arith_lane (
        .clk(clk), .reset(reset), .capture_i(w_capture), .issue_i(issue_q),
        .data_i(q_arith), .ready_i(arith_ready), .valid_o(arith_valid),
        .instr_o(arith_op), .pending_d_o(arith_pend_d)
    );

    issue_lane #(.W(CACHE_INSTR_W), .ACT_BIT(CACHE_ACT_BIT)) u_cache_lane (
        .clk(clk), .reset(reset), .capture_i(w_capture), .issue_i(issue_q),
        .data_i(q_cache), .ready_i(cache_ready), .valid_o(cache_valid),
        .instr_o(cache_instr), .pending_d_o(cache_pend_d)
    );

    // CAPTURE and ISSUE share the exit rule: leave once nothing stays pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_can_read) state_d = READ;
            READ:    state_d = CAPTURE;
            CAPTURE,
            ISSUE: begin
                if (w_any_pend_d)    state_d = ISSUE;
                else if (w_can_read) state_d = READ;
                else                 state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q_re_q  <= 1'b0;
            busy_q  <= 1'b0;
            issue_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_re_q  <= (state_d == READ);
            busy_q  <= (state_d != IDLE);
            issue_q <= (state_d == ISSUE);
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic        w_stall;
    logic [15:0] stall_cnt_q;
    logic [15:0] bundle_cnt_q;

    assign w_stall    = (dma_valid & ~dma_ready) | (arith_valid & ~arith_ready)
                      | (cache_valid & ~cache_ready);
    assign stall_cnt  = stall_cnt_q;
    assign bundle_cnt = bundle_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bundle_cnt_q <= '0;
        end else begin
            if (w_stall && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (w_capture)
                bundle_cnt_q <= bundle_cnt_q + 16'd1;
        end
    end
`endif

endmodule : instr_issue
`default_nettype wire

// File: tb/tb_instr_issue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_instr_issue : scoreboard bench for instr_issue                   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_instr_issue;

    logic        clk = 1'b0;
    logic        reset, run, q_re, q_empty, busy;
    logic [21:0] q_dma, dma_instr;
    logic [0:0]  q_arith, arith_op;
    logic [16:0] q_cache, cache_instr;
    logic        dma_valid, dma_ready, arith_valid, arith_ready, cache_valid, cache_ready;
`ifdef ISSUE_PERF_CNT_EN
    logic [15:0] stall_cnt, bundle_cnt;
`endif

    always #5 clk = ~clk;

    instr_issue dut (
        .clk(clk), .reset(reset), .run(run), .q_re(q_re),
        .q_dma(q_dma), .q_arith(q_arith), .q_cache(q_cache), .q_empty(q_empty),
        .dma_valid(dma_valid), .dma_instr(dma_instr), .dma_ready(dma_ready),
        .arith_valid(arith_valid), .arith_op(arith_op), .arith_ready(arith_ready),
        .cache_valid(cache_valid), .cache_instr(cache_instr), .cache_ready(cache_ready),
        .busy(busy)
`ifdef ISSUE_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .bundle_cnt(bundle_cnt)
`endif
    );

    // Instruction queue model: data appears the cycle after the read strobe.
    logic [21:0] pd [0:511];
    logic [0:0]  pa [0:511];
    logic [16:0] pc [0:511];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign q_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (q_re && !reset) begin
            q_dma   <= pd[rd_ptr % 512];
            q_arith <= pa[rd_ptr % 512];
            q_cache <= pc[rd_ptr % 512];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    logic [21:0] exp_dma[$];
    logic [0:0]  exp_arith[$];
    logic [16:0] exp_cache[$];

    int compared = 0, mismatched = 0;
    int cyc = 0;
    int qre_cyc[$];
    int qre_since_rst = 0, stall_m = 0, busy_cyc = 0, dma_stall_cyc = 0;
    int vcnt_dma = 0, vcnt_arith = 0, vcnt_cache = 0;
    int vcyc_dma = 0, vcyc_arith = 0, vcyc_cache = 0;
    int acc_dma = 0, acc_cache = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bundle(input logic [21:0] d, input logic [0:0] a, input logic [16:0] c);
        pd[wr_ptr % 512] = d;
        pa[wr_ptr % 512] = a;
        pc[wr_ptr % 512] = c;
        if (d[21]) exp_dma.push_back(d);
        if (a[0])  exp_arith.push_back(a);
        if (c[16]) exp_cache.push_back(c);
        wr_ptr++;
    endtask

    task automatic clear_stats();
        qre_cyc.delete();
        busy_cyc = 0; dma_stall_cyc = 0;
        vcnt_dma = 0; vcnt_arith = 0; vcnt_cache = 0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n = 0;
        while (!(busy == 1'b0 && wr_ptr == rd_ptr) && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) fail_bound(name);
        tick();
    endtask

    task automatic wait_dma_valid(input string name, input int maxc);
        int n = 0;
        while (!dma_valid && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) fail_bound(name);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        exp_dma.delete(); exp_arith.delete(); exp_cache.delete();
        tick();
        reset = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: lane outputs are stable at the falling edge; valid&ready here is an accept.
    always @(negedge clk) begin
        if (reset) begin
            stall_m = 0;
            qre_since_rst = 0;
        end else begin
            if (q_re) begin
                qre_cyc.push_back(cyc);
                qre_since_rst++;
                check("barrier_valids", {29'd0, dma_valid, arith_valid, cache_valid}, 32'd0);
            end
            if (!busy) check("idle_valids", {29'd0, dma_valid, arith_valid, cache_valid}, 32'd0);
            if (busy) busy_cyc++;
            if ((dma_valid && !dma_ready) || (arith_valid && !arith_ready)
                || (cache_valid && !cache_ready)) begin
                if (stall_m < 65535) stall_m++;
            end
            if (dma_valid) begin
                vcnt_dma++; vcyc_dma = cyc;
                if (!dma_ready) dma_stall_cyc++;
                if (exp_dma.size() == 0) check("dma_valid_unexpected", 32'(dma_valid), 32'd0);
                else begin
                    check("dma_instr", 32'(dma_instr), 32'(exp_dma[0]));
                    if (dma_ready) begin void'(exp_dma.pop_front()); acc_dma = cyc; end
                end
            end
            if (arith_valid) begin
                vcnt_arith++; vcyc_arith = cyc;
                if (exp_arith.size() == 0) check("arith_valid_unexpected", 32'(arith_valid), 32'd0);
                else begin
                    check("arith_op", 32'(arith_op), 32'(exp_arith[0]));
                    if (arith_ready) void'(exp_arith.pop_front());
                end
            end
            if (cache_valid) begin
                vcnt_cache++; vcyc_cache = cyc;
                if (exp_cache.size() == 0) check("cache_valid_unexpected", 32'(cache_valid), 32'd0);
                else begin
                    check("cache_instr", 32'(cache_instr), 32'(exp_cache[0]));
                    if (cache_ready) begin void'(exp_cache.pop_front()); acc_cache = cyc; end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run = 1'b0;
        dma_ready = 1'b1; arith_ready = 1'b1; cache_ready = 1'b1;
        tick();
        check("rst_q_re", 32'(q_re), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_valids", {29'd0, dma_valid, arith_valid, cache_valid}, 0);
        check("rst_instrs", {14'd0, dma_instr[16:0] | cache_instr, arith_op}, 0);
        check("rst_dma_instr_hi", 32'(dma_instr), 0);
        tick();
        reset = 1'b0;
        tick();

        // Reference program: one active lane per bundle, then two bubbles.
        clear_stats();
        push_bundle(22'h280000, 1'b0, 17'h00000);
        push_bundle(22'h000000, 1'b0, 17'h18000);
        push_bundle(22'h000000, 1'b1, 17'h00000);
        push_bundle(22'h000000, 1'b0, 17'h00000);
        push_bundle(22'h000000, 1'b0, 17'h00000);
        run = 1'b1;
        wait_idle("prog_idle", 100);
        check("prog_qre_count", qre_cyc.size(), 5);
        check("prog_dma_pulses", vcnt_dma, 1);
        check("prog_arith_pulses", vcnt_arith, 1);
        check("prog_cache_pulses", vcnt_cache, 1);
        check("prog_dma_cycle", vcyc_dma, qre_cyc[0] + 2);
        check("prog_cache_cycle", vcyc_cache, qre_cyc[1] + 2);
        check("prog_arith_cycle", vcyc_arith, qre_cyc[2] + 2);
        check("prog_busy_cycles", busy_cyc, 13);
        check("issue_read_gap", qre_cyc[1] - qre_cyc[0], 3);
        check("bubble_read_gap", qre_cyc[4] - qre_cyc[3], 2);
`ifdef ISSUE_PERF_CNT_EN
        check("prog_bundle_cnt", 32'(bundle_cnt), 5);
        check("prog_stall_cnt", 32'(stall_cnt), 0);
`endif

        // DMA stalled for five issue cycles while cache retires at once.
        run = 1'b0;
        pulse_reset();
        clear_stats();
        dma_ready = 1'b0; cache_ready = 1'b1; arith_ready = 1'b1;
        push_bundle(22'h3ABCDE, 1'b0, 17'h1F00D);
        push_bundle(22'h000000, 1'b1, 17'h00000);
        run = 1'b1;
        wait_dma_valid("stall_dma_valid", 50);
        repeat (5) @(posedge clk);
        #1;
        dma_ready = 1'b1;
        wait_idle("stall_idle", 100);
        check("stall_cache_pulses", vcnt_cache, 1);
        check("stall_cache_cycle", acc_cache, qre_cyc[0] + 2);
        check("stall_dma_valid_cycles", vcnt_dma, 6);
        check("stall_dma_stalled", dma_stall_cyc, 5);
        check("stall_next_read", qre_cyc[1], acc_dma + 1);
`ifdef ISSUE_PERF_CNT_EN
        check("stall_cnt_five", 32'(stall_cnt), 5);
        check("stall_bundle_cnt", 32'(bundle_cnt), 2);
`endif

        // Simultaneous accept of dma and cache.
        clear_stats();
        dma_ready = 1'b0; cache_ready = 1'b0;
        push_bundle(22'h212345, 1'b0, 17'h10ABC);
        push_bundle(22'h000000, 1'b0, 17'h00000);
        wait_dma_valid("simul_dma_valid", 50);
        tick(); tick();
        dma_ready = 1'b1; cache_ready = 1'b1;
        wait_idle("simul_idle", 100);
        check("simul_same_edge", acc_dma, acc_cache);
        check("simul_next_read", qre_cyc[1], acc_dma + 1);

        // Reset while a dma instruction is stalled.
        dma_ready = 1'b0;
        push_bundle(22'h2FFFFF, 1'b0, 17'h00000);
        wait_dma_valid("rst_mid_dma_valid", 50);
        tick();
        #2;
        reset = 1'b1;
        exp_dma.delete(); exp_arith.delete(); exp_cache.delete();
        run = 1'b0;
        #1;
        check("rstmid_dma_valid", 32'(dma_valid), 0);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_dma_instr", 32'(dma_instr), 0);
`ifdef ISSUE_PERF_CNT_EN
        check("rstmid_stall_cnt", 32'(stall_cnt), 0);
        check("rstmid_bundle_cnt", 32'(bundle_cnt), 0);
`endif
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("rstmid_no_valid_after", {29'd0, dma_valid, arith_valid, cache_valid}, 0);
        check("rstmid_idle", 32'(busy), 0);

        // run dropped mid-issue: bundle completes, no further read until run returns.
        clear_stats();
        push_bundle(22'h200001, 1'b0, 17'h00000);
        push_bundle(22'h000000, 1'b0, 17'h10001);
        run = 1'b1;
        wait_dma_valid("run0_dma_valid", 50);
        run = 1'b0;
        repeat (3) tick();
        dma_ready = 1'b1;
        repeat (5) tick();
        check("run0_idle", 32'(busy), 0);
        check("run0_dma_done", vcnt_dma, 4);
        check("run0_no_read", qre_cyc.size(), 1);
        run = 1'b1;
        wait_idle("run0_resume_idle", 100);
        check("run0_resumed_read", qre_cyc.size(), 2);
        check("run0_cache_done", vcnt_cache, 1);

        // Randomized traffic with random readies and run gaps.
        begin
            int pushed = 0;
            int n = 0;
            logic [21:0] d;
            logic [16:0] c;
            logic [0:0]  a;
            while ((pushed < 100 || busy || wr_ptr != rd_ptr) && n < 6000) begin
                tick();
                n++;
                dma_ready   = ($urandom_range(0, 3) != 0);
                arith_ready = ($urandom_range(0, 3) != 0);
                cache_ready = ($urandom_range(0, 3) != 0);
                run         = (pushed >= 100) || ($urandom_range(0, 7) != 0);
                if (pushed < 100 && $urandom_range(0, 2) == 0) begin
                    d = 22'($urandom); d[21] = 1'($urandom_range(0, 1));
                    c = 17'($urandom); c[16] = 1'($urandom_range(0, 1));
                    a = 1'($urandom_range(0, 1));
                    push_bundle(d, a, c);
                    pushed++;
                end
            end
            if (n >= 6000) fail_bound("random_drain");
            tick();
        end
        check("rand_dma_left", exp_dma.size(), 0);
        check("rand_arith_left", exp_arith.size(), 0);
        check("rand_cache_left", exp_cache.size(), 0);
`ifdef ISSUE_PERF_CNT_EN
        check("rand_stall_cnt", 32'(stall_cnt), 32'(stall_m));
        check("rand_bundle_cnt", 32'(bundle_cnt), 32'(qre_since_rst[15:0]));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_instr_issue
`default_nettype wire
